// File: rtl/lut_exp_pkg.sv
// Shared exponential table T(u) = min(255, floor(16*2^((u-128)/32))) plus FSM
// encoding; used by lut_logarithm and lut_exponential.
package lut_exp_pkg;

  localparam int SZ    = 8;
  localparam int TBL_N = 256;
  localparam int BIG_W = 264;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_DONE
  } state_e;

  typedef logic [TBL_N-1:0][7:0] tbl_t;

  function automatic logic [BIG_W-1:0] pow32(
    input logic [BIG_W-1:0] x
  );
    logic [BIG_W-1:0] p;
    p = x;
    for (int i = 0; i < 5; i++) p = p * p;
    return p;
  endfunction

  // Exact integer floor: v = T(u) iff v^32 <= 2^u < (v+1)^32, capped at 255.
  function automatic tbl_t build_tbl();
    tbl_t t;
    int   v;
    t = '0;
    v = 1;
    for (int u = 0; u < TBL_N; u++) begin
      while (v < 255 &&
             pow32(BIG_W'(v + 1)) <= (BIG_W'(1) << u))
        v++;
      t[u] = 8'(v);
    end
    return t;
  endfunction

  localparam tbl_t       EXP_TBL = build_tbl();
  localparam logic [7:0] T_MIN   = EXP_TBL[0];

endpackage

// File: rtl/lut_logarithm_if.sv
// Request/result handshake bundle for lut_logarithm.
interface lut_logarithm_if #(
  parameter int SZ = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [SZ-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [SZ-1:0] out_angle;
  logic          out_sat;

  modport master (
    output in_valid, in_exp, out_ready,
    input  in_ready, out_valid, out_angle, out_sat
  );

  modport slave (
    input  in_valid, in_exp, out_ready,
    output in_ready, out_valid, out_angle, out_sat
  );
endinterface

// File: rtl/lut_logarithm_exp_table_rom.sv
// Combinational exponential table lookup, indexed by offset code u.
module exp_table_rom
  import lut_exp_pkg::*;
(
  input  logic [SZ-1:0] idx,
  output logic [7:0]    val
);

  assign val = EXP_TBL[idx];

endmodule

// File: rtl/lut_logarithm.sv
// Floor-inverse of the exponential table by bitwise binary search.
// Optional conv_cnt counter enabled by LUT_LOG_PERF_CNT_EN.
module lut_logarithm
  import lut_exp_pkg::*;
#(
  parameter int SZ    = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  lut_logarithm_if.slave bus
`ifdef LUT_LOG_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] conv_cnt
`endif
);

  localparam int BW = $clog2(SZ);

  if (SZ != 8 || CNT_W < 1) begin : g_cfg_err
    $error("lut_logarithm: SZ must be 8, CNT_W >= 1");
  end

  state_e        state_q, state_d;
  logic [SZ-1:0] target_q, target_d;
  logic [SZ-1:0] u_q, u_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sat_q, sat_d;
  logic [SZ-1:0] angle_q, angle_d;
  logic          osat_q, osat_d;
  logic          ovld_q, ovld_d;
  logic          ird_q, ird_d;

  logic [SZ-1:0] trial;
  logic [7:0]    t_val;
  logic          keep;
  logic          out_hs;

  assign trial  = u_q | (SZ'(1) << bit_q);
  assign keep   = t_val <= target_q;
  assign out_hs = ovld_q & bus.out_ready;

  exp_table_rom u_rom (
    .idx (trial),
    .val (t_val)
  );

`ifdef LUT_LOG_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conv_cnt = cnt_q;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    u_d      = u_q;
    bit_d    = bit_q;
    sat_d    = sat_q;
    angle_d  = angle_q;
    osat_d   = osat_q;
    ovld_d   = ovld_q;
    ird_d    = ird_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && ird_q) begin
          target_d = bus.in_exp;
          u_d      = '0;
          bit_d    = BW'(SZ - 1);
          ird_d    = 1'b0;
          state_d  = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        // Saturation only depends on the table minimum at a = -128.
        if (bit_q == BW'(SZ - 1))
          sat_d = target_q < T_MIN;
        if (keep) u_d = trial;
        if (bit_q == '0) state_d = ST_DONE;
        else             bit_d   = bit_q - 1'b1;
      end
      ST_DONE: begin
        if (!ovld_q) begin
          ovld_d  = 1'b1;
          angle_d = u_q ^ {1'b1, {(SZ-1){1'b0}}};
          osat_d  = sat_q;
        end else if (bus.out_ready) begin
          ovld_d  = 1'b0;
          ird_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ird_d   = 1'b1;
        ovld_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      u_q      <= '0;
      bit_q    <= '0;
      sat_q    <= 1'b0;
      angle_q  <= '0;
      osat_q   <= 1'b0;
      ovld_q   <= 1'b0;
      ird_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      u_q      <= u_d;
      bit_q    <= bit_d;
      sat_q    <= sat_d;
      angle_q  <= angle_d;
      osat_q   <= osat_d;
      ovld_q   <= ovld_d;
      ird_q    <= ird_d;
    end
  end

  assign bus.in_ready  = ird_q;
  assign bus.out_valid = ovld_q;
  assign bus.out_angle = angle_q;
  assign bus.out_sat   = osat_q;

endmodule

// File: tb/tb_lut_logarithm.sv
// Bench for lut_logarithm: directed corners, random jobs and a full sweep
// against a real-arithmetic floor-inverse model.
module tb_lut_logarithm;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lut_logarithm_if #(.SZ(8)) bus ();

`ifdef LUT_LOG_PERF_CNT_EN
  logic [15:0] conv_cnt;
`endif

  lut_logarithm #(
    .SZ    (8),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef LUT_LOG_PERF_CNT_EN
    ,
    .conv_cnt (conv_cnt)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;
  int   ref_angle [256];
  logic ref_sat   [256];

  function automatic int t_ref(input int a);
    real r;
    int  v;
    r = 16.0 * (2.0 ** (a / 32.0));
    v = int'($floor(r));
    return (v > 255) ? 255 : v;
  endfunction

  task automatic build_model();
    for (int e = 0; e < 256; e++) begin
      ref_angle[e] = -128;
      ref_sat[e]   = (t_ref(-128) > e);
      for (int a = -128; a < 128; a++)
        if (t_ref(a) <= e) ref_angle[e] = a;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic conv(input logic [7:0] e,
                      input int hold,
                      input bit intrude);
    int         k;
    logic [7:0] ea;
    logic [7:0] a0;
    logic       s0;
    ea = 8'(ref_angle[e]);
    k = 0;
    while (!bus.in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_exp   = e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'd9);
    chk("angle", 32'(bus.out_angle), 32'(ea));
    chk("sat", 32'(bus.out_sat), 32'(ref_sat[e]));
    a0 = bus.out_angle;
    s0 = bus.out_sat;
    for (int i = 0; i < hold; i++) begin
      if (intrude) begin
        bus.in_valid = 1'b1;
        bus.in_exp   = ~e;
      end
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_angle", 32'(bus.out_angle), 32'(a0));
      chk("hold_sat", 32'(bus.out_sat), 32'(s0));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt++;
    chk("post_valid", 32'(bus.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    build_model();
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_angle", 32'(bus.out_angle), 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
`ifdef LUT_LOG_PERF_CNT_EN
    chk("rst_cnt", 32'(conv_cnt), 32'd0);
`endif
    rst = 1'b0;

    conv(8'd64, 0, 1'b0);
    conv(8'd16, 0, 1'b0);
    conv(8'd255, 0, 1'b0);
    conv(8'd0, 0, 1'b0);
    conv(8'd1, 0, 1'b0);
    conv(8'd100, 5, 1'b1);

    bus.in_valid = 1'b1;
    bus.in_exp   = 8'd200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_rst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
    end
    conv(8'd64, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      conv(8'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
`ifdef LUT_LOG_PERF_CNT_EN
    chk("cnt_mid", 32'(conv_cnt), 32'(exp_cnt));
`endif

    pulse_reset();
    for (int e = 0; e < 256; e++)
      conv(8'(e), 0, 1'b0);
`ifdef LUT_LOG_PERF_CNT_EN
    chk("cnt_sweep", 32'(conv_cnt), 32'd256);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
